// File: rtl/dbus_mem.sv
`default_nettype none
// ============================================================================
//  Module      : dbus_mem
//  Description : Word-addressed 32-bit data-bus memory with little-endian
//                byte-lane writes, asynchronous whole-array clear and
//                combinational (default) or registered read data.
//                Optional macro: DBUS_MEM_RDREG_EN registers data_o
//                (one-cycle read latency).
//  Revision    : 1.0 - initial release
// ============================================================================
module dbus_mem #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [29:0] address,
  input  logic [31:0] data_i,
  input  logic        rd,
  input  logic        wr,
  input  logic [3:0]  byte_enable,
  output logic [31:0] data_o
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [31:0]           mem_q [DEPTH];
  logic [31:0]           mem_d [DEPTH];
  logic [ADDR_WIDTH-1:0] word_idx;

  // Only the low address bits select a word; higher bits alias the array.
  assign word_idx = address[ADDR_WIDTH-1:0];

  generate
    if (ADDR_WIDTH < 30) begin : g_addr_hi
      logic unused_addr_hi;
      assign unused_addr_hi = ^address[29:ADDR_WIDTH];
    end
  endgenerate

  // Next memory contents: merge each enabled byte lane of data_i into the word.
  always_comb begin
    mem_d = mem_q;
    if (wr) begin
      for (int k = 0; k < 4; k++) begin
        if (byte_enable[k]) begin
          mem_d[word_idx][8*k +: 8] = data_i[8*k +: 8];
        end
      end
    end
  end

  // Memory array: reset clears every word and blocks writes while held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

`ifdef DBUS_MEM_RDREG_EN
  logic [31:0] rdata_d;
  logic [31:0] rdata_q;

  // Read capture value: the pre-write word when rd is high, otherwise zero.
  always_comb begin
    rdata_d = '0;
    if (rd) begin
      rdata_d = mem_q[word_idx];
    end
  end

  // Registered read data, one cycle behind the request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign data_o = rdata_q;
`else
  // Combinational read of the stored (pre-write) word; zero when idle or in reset.
  always_comb begin
    data_o = '0;
    if (rd && !rst) begin
      data_o = mem_q[word_idx];
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_dbus_mem.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dbus_mem
//  Description : Self-checking bench for dbus_mem (directed steps with an
//                expected-value queue). Follows DBUS_MEM_RDREG_EN if defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_dbus_mem;

  logic        clk;
  logic        rst;
  logic [29:0] address;
  logic [31:0] data_i;
  logic        rd;
  logic        wr;
  logic [3:0]  byte_enable;
  logic [31:0] data_o;

  int          tests_run;
  int          tests_failed;
  logic [31:0] exp_q [$];

  dbus_mem #(.ADDR_WIDTH(10)) dut (
    .clk         (clk),
    .rst         (rst),
    .address     (address),
    .data_i      (data_i),
    .rd          (rd),
    .wr          (wr),
    .byte_enable (byte_enable),
    .data_o      (data_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1, "watchdog expired");
  end

  // Pop the oldest expected value and compare it with data_o.
  task automatic check(input string tag);
    logic [31:0] e;
    tests_run++;
    if (exp_q.size() == 0) begin
      tests_failed++;
      $display("FAIL %s: observed %h but scoreboard empty, required an expected entry", tag, data_o);
    end else begin
      e = exp_q.pop_front();
      assert (data_o === e) else begin
        tests_failed++;
        $error("FAIL %s: observed %h required %h", tag, data_o, e);
      end
    end
  endtask

  task automatic do_write(input logic [29:0] a, input logic [31:0] d, input logic [3:0] be);
    @(negedge clk);
    address = a; data_i = d; byte_enable = be; wr = 1'b1; rd = 1'b0;
    @(negedge clk);
    wr = 1'b0; byte_enable = 4'b0000;
  endtask

  // Issue a read and compare once the data is due (same cycle or next edge).
  task automatic do_read(input logic [29:0] a, input logic [31:0] e, input string tag);
    @(negedge clk);
    address = a; rd = 1'b1; wr = 1'b0;
    exp_q.push_back(e);
`ifdef DBUS_MEM_RDREG_EN
    @(posedge clk);
`endif
    #1;
    check(tag);
    rd = 1'b0;
  endtask

  initial begin
    tests_run = 0; tests_failed = 0;
    rst = 1'b1; address = '0; data_i = '0; rd = 1'b1; wr = 1'b0; byte_enable = '0;
    repeat (2) @(posedge clk);
    #1;
    exp_q.push_back(32'h0);
    check("reset_out_rd1");
    @(negedge clk);
    rst = 1'b0; rd = 1'b0;

    // Full-word write then byte-lane merges.
    do_write(30'h4, 32'h12345678, 4'b1111);
    do_read (30'h4, 32'h12345678, "full_word");
    do_write(30'h4, 32'hAABBCCDD, 4'b0001);
    do_read (30'h4, 32'h123456DD, "lane0");
    do_write(30'h4, 32'h9988FFFF, 4'b1100);
    do_read (30'h4, 32'h998856DD, "lanes23");
    do_write(30'h4, 32'h00000000, 4'b0000);
    do_read (30'h4, 32'h998856DD, "be_zero");

    // Byte enables ignored when wr is low.
    @(negedge clk);
    address = 30'h4; data_i = 32'h0; byte_enable = 4'b1111; wr = 1'b0; rd = 1'b0;
    @(negedge clk);
    byte_enable = 4'b0000;
    do_read (30'h4, 32'h998856DD, "wr0_be_ignored");

    // rd low yields zero.
    @(negedge clk);
    address = 30'h4; rd = 1'b0;
    exp_q.push_back(32'h0);
`ifdef DBUS_MEM_RDREG_EN
    @(posedge clk);
`endif
    #1;
    check("rd0_zero");

    // Aliasing modulo depth and array boundaries.
    do_write(30'h005, 32'hCAFEF00D, 4'b1111);
    do_read (30'h405, 32'hCAFEF00D, "alias_405");
    do_read (30'h3FFFFC05, 32'hCAFEF00D, "alias_high");
    do_write(30'h3FF, 32'h5A5A0FF0, 4'b1111);
    do_read (30'h3FF, 32'h5A5A0FF0, "top_word");
    do_write(30'h000, 32'h0BADBEEF, 4'b1111);
    do_read (30'h400, 32'h0BADBEEF, "word0_alias");

    // Same-cycle read/write collision.
    do_write(30'h8, 32'h11111111, 4'b1111);
    @(negedge clk);
    address = 30'h8; data_i = 32'h22222222; byte_enable = 4'b1111; rd = 1'b1; wr = 1'b1;
    exp_q.push_back(32'h11111111);
    exp_q.push_back(32'h22222222);
`ifdef DBUS_MEM_RDREG_EN
    @(posedge clk);
`endif
    #1;
    check("collision_old");
    @(posedge clk);
    #1;
    check("collision_new");
    @(negedge clk);
    rd = 1'b0; wr = 1'b0; byte_enable = 4'b0000;

    // Asynchronous reset between edges, with a write held across it.
    @(negedge clk);
    address = 30'h4; rd = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    exp_q.push_back(32'h0);
    check("reset_async_out");
    address = 30'h20; data_i = 32'hDEADBEEF; byte_enable = 4'b1111; wr = 1'b1;
    @(posedge clk);
    #1;
    exp_q.push_back(32'h0);
    check("reset_hold_out");
    @(negedge clk);
    #2;
    rst = 1'b0; wr = 1'b0; rd = 1'b0; byte_enable = 4'b0000;
    do_read(30'h20, 32'h0, "write_in_reset_dropped");
    for (int i = 0; i < 1024; i++) begin
      do_read(30'(i), 32'h0, "cleared_word");
    end

    // First write after reset is accepted.
    do_write(30'h10, 32'hA5A5A5A5, 4'b1111);
    do_read (30'h10, 32'hA5A5A5A5, "post_reset_write");

    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL scoreboard_drain: observed %0d leftover entries required 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dbus_mem.md
DBUS_MEM -- requirements
Module: dbus_mem

Interface
- REQ-001 SHALL have parameter: ADDR_WIDTH, default 10, number of word-address bits decoded (depth 2^ADDR_WIDTH 32-bit words).
- REQ-002 SHALL have port: clk  input  1  single clock; all writes on rising edge.
- REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-high.
- REQ-004 SHALL have port: address  input  30  word address (CPU byte address bits [31:2]).
- REQ-005 SHALL have port: data_i  input  32  write data.
- REQ-006 SHALL have port: rd  input  1  read enable.
- REQ-007 SHALL have port: wr  input  1  write enable.
- REQ-008 SHALL have port: byte_enable  input  4  per-byte write lane enable.
- REQ-009 SHALL have port: data_o  output  32  read data.

Function
- REQ-010 SHALL decode only address[ADDR_WIDTH-1:0]; upper bits ignored, so addresses alias modulo depth.
- REQ-011 SHALL use little-endian lanes: byte_enable[k] controls data bits [8k+7:8k], k=0..3.
- REQ-012 SHALL, on rising clk with wr=1, write each enabled lane of data_i into the addressed word; disabled lanes keep prior contents.
- REQ-013 SHALL ignore byte_enable when wr=0; wr=1 with byte_enable=0000 leaves memory unchanged.
- REQ-014 SHALL, in default build, drive data_o combinationally with the full addressed word when rd=1, independent of byte_enable (CPU extracts bytes/halfwords).
- REQ-015 SHALL drive data_o = 0x00000000 when rd=0 (default build).
- REQ-016 SHALL, for rd=1 and wr=1 to the same address in the same cycle, return pre-write contents during that cycle; new contents visible from the next cycle.
- REQ-017 SHALL not produce X on data_o for any in-range or aliased address after reset.

Reset
- REQ-018 SHALL, while rst=1, clear every memory word to 0x00000000 asynchronously and block all writes.
- REQ-019 SHALL, while rst=1, output data_o = 0x00000000 regardless of rd.
- REQ-020 SHALL, when rst asserts mid-write cycle, discard that write; the first write is accepted on the first rising clk with rst=0.

Configuration
- REQ-021 SHALL support macro DBUS_MEM_RDREG_EN: when defined, data_o is registered — captured on the rising edge where rd=1 (else captures 0), one-cycle read latency, reset to 0; same-cycle rd/wr same address returns pre-write word.
- REQ-022 SHALL, without DBUS_MEM_RDREG_EN, implement the combinational read of REQ-014..REQ-016 with zero latency.

Verification
- REQ-023 SHALL verify full-word write: wr=1, be=1111, address=0x4, data_i=0x12345678; then rd=1 address=0x4 -> data_o=0x12345678.
- REQ-024 SHALL verify byte lanes: word 0x4 holds 0x12345678; write be=0001 data_i=0xAABBCCDD -> read 0x123456DD; then be=1100 data_i=0x9988FFFF -> read 0x998856DD.
- REQ-025 SHALL verify aliasing with ADDR_WIDTH=10: write 0xCAFEF00D at address 0x005 -> read at address 0x405 returns 0xCAFEF00D.
- REQ-026 SHALL verify read/write collision: word 0x8=0x11111111; same cycle rd=1, wr=1, be=1111, data_i=0x22222222 -> data_o=0x11111111 that cycle (default build), 0x22222222 next cycle.
- REQ-027 SHALL verify reset: after writes, pulse rst asynchronously between edges -> data_o=0 immediately; every word subsequently reads 0x00000000.
- REQ-028 SHALL verify rd=0 -> data_o=0x00000000; with DBUS_MEM_RDREG_EN, read of 0x12345678 appears exactly one clk after rd asserts.
